// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED matrix scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package led_scan_pkg;

    // Scanner phase: all-off blanking gap, then the row's ON window.
    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    // Width of the row index; never narrower than one bit.
    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Flat bit position of pixel (row, col) in a row-major frame vector.
    function automatic int pix_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Frame loading channel: one full ROWS x COLS bitmap per valid/ready transfer.
// Latency: transfer completes on the clock edge where valid and ready are both high.
// Backpressure: the scanner holds ready low while its pending buffer is occupied.
interface led_matrix_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic [ROWS*COLS-1:0] frame_d;
    logic                 frame_valid;
    logic                 frame_ready;

    modport master (output frame_d, output frame_valid, input  frame_ready);
    modport slave  (input  frame_d, input  frame_valid, output frame_ready);
endinterface

// File: rtl/led_frame_buf.sv
// Double frame buffer: pending slot filled by the loader, active slot read by the scanner.
// Latency: accepted frame lands in pending on the transfer edge; moves to active on the next swap.
// Backpressure: frame_ready is the registered inverse of the pending-full flag.
module led_frame_buf #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    led_matrix_scan_if.slave     frame_if,
    input  logic                 swap,
    output logic [ROWS*COLS-1:0] active
);
    localparam int NPIX = ROWS * COLS;

    logic [NPIX-1:0] pending;
    logic            pend_full;
    logic            pend_full_nx;
    logic            accept;
    logic            promote;

    // A transfer needs ready, and ready implies an empty pending slot, so
    // accept and promote can never fire on the same edge.
    assign accept  = frame_if.frame_valid & frame_if.frame_ready;
    assign promote = swap & pend_full;

    // Next occupancy of the pending slot.
    always_comb begin
        pend_full_nx = pend_full;
        if (accept) begin
            pend_full_nx = 1'b1;
        end else if (promote) begin
            pend_full_nx = 1'b0;
        end
    end

    // Buffer storage, occupancy flag and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending              <= '0;
            active               <= '0;
            pend_full            <= 1'b0;
            frame_if.frame_ready <= 1'b0;
        end else begin
            if (accept) begin
                pending <= frame_if.frame_d;
            end
            if (promote) begin
                active <= pending;
            end
            pend_full            <= pend_full_nx;
            frame_if.frame_ready <= ~pend_full_nx;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed ROWS x COLS LED scanner: per-row blanking gap, ON window of div_i+1 clocks, global PWM.
// Latency: all outputs registered; a loaded frame is shown from the next row-0 boundary (tear-free swap).
// Backpressure: frame_ready low while a frame waits in the pending buffer. Option: LED_SCAN_SKIP_EMPTY_EN.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter  int ROWS         = 8,
    parameter  int COLS         = 8,
    parameter  int DIV_W        = 12,
    parameter  int PWM_BITS     = 4,
    parameter  int BLANK_CYCLES = 2,
    localparam int RW           = row_w(ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_W-1:0]    div_i,
    input  logic [PWM_BITS-1:0] brightness,
    led_matrix_scan_if.slave    frame_if,
    output logic [ROWS-1:0]     row_on,
    output logic [COLS-1:0]     col_on,
    output logic [RW-1:0]       row_idx,
    output logic                frame_start
);
    localparam int NPIX  = ROWS * COLS;
    localparam int BW    = $clog2(BLANK_CYCLES) + 1;
    localparam int CNT_W = (DIV_W > BW) ? DIV_W : BW;

    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [RW-1:0]       ROW_LAST   = RW'(ROWS - 1);
    localparam logic [PWM_BITS-1:0] PWM_FULL   = '1;
    localparam logic [ROWS-1:0]     ROW_ONE    = {{(ROWS-1){1'b0}}, 1'b1};

    scan_state_t         state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [RW-1:0]       row_nx;
    logic [RW-1:0]       row_inc;
    logic                row_wrap;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_nx;
    logic                running;
    logic                adv;
    logic                swap;
    logic                fs_nx;
    logic                lit_nx;
    logic                skip_row;
    logic [ROWS-1:0]     row_on_nx;
    logic [COLS-1:0]     col_on_nx;
    logic [NPIX-1:0]     active;
    logic [COLS-1:0]     row_bits;

    led_frame_buf #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_frame_buf (
        .clk      (clk),
        .rst      (rst),
        .frame_if (frame_if),
        .swap     (swap),
        .active   (active)
    );

    // Pixel bits of the row being scanned, taken from the displayed buffer.
    assign row_bits = active[pix_idx(int'(row_idx), 0, COLS) +: COLS];

    assign row_wrap = (row_idx == ROW_LAST);
    assign row_inc  = row_wrap ? '0 : row_idx + 1'b1;

`ifdef LED_SCAN_SKIP_EMPTY_EN
    // Dark rows give up their ON window, so sparse images refresh faster.
    assign skip_row = (row_bits == '0);
`else
    assign skip_row = 1'b0;
`endif

    // Next-state, counters and the registered-output values for the coming cycle.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        row_nx    = row_idx;
        pwm_nx    = pwm_cnt;
        adv       = 1'b0;
        swap      = 1'b0;
        fs_nx     = 1'b0;
        lit_nx    = 1'b0;
        row_on_nx = '0;
        col_on_nx = '0;

        if (!running) begin
            // First cycle out of reset opens the blanking gap of row 0.
            state_nx = S_BLANK;
            cnt_nx   = BLANK_LAST;
            row_nx   = '0;
            fs_nx    = 1'b1;
        end else begin
            unique case (state)
                S_BLANK: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 1'b1;
                    end else if (skip_row) begin
                        adv = 1'b1;
                    end else begin
                        // ON length is fixed here; later div_i edits wait for the next row.
                        state_nx = S_ON;
                        cnt_nx   = CNT_W'(div_i);
                        pwm_nx   = '0;
                    end
                end
                S_ON: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 1'b1;
                        pwm_nx = pwm_cnt + 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
                default: begin
                    state_nx = S_BLANK;
                    cnt_nx   = BLANK_LAST;
                end
            endcase

            if (adv) begin
                // Leaving a row: blank the next one; wrapping to row 0 is the only swap point.
                state_nx = S_BLANK;
                cnt_nx   = BLANK_LAST;
                row_nx   = row_inc;
                swap     = row_wrap;
                fs_nx    = row_wrap;
            end
        end

        lit_nx = (brightness == PWM_FULL) || (pwm_nx < brightness);

        // An ON cycle always stays on the current row, so row_bits is the right slice.
        if (state_nx == S_ON) begin
            row_on_nx = ROW_ONE << row_nx;
            col_on_nx = row_bits & {COLS{lit_nx}};
        end
    end

    // Scanner state and registered matrix drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BLANK;
            cnt         <= '0;
            row_idx     <= '0;
            pwm_cnt     <= '0;
            running     <= 1'b0;
            row_on      <= '0;
            col_on      <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            row_idx     <= row_nx;
            pwm_cnt     <= pwm_nx;
            running     <= 1'b1;
            row_on      <= row_on_nx;
            col_on      <= col_on_nx;
            frame_start <= fs_nx;
        end
    end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
Parametrised row-multiplexed LED matrix scanner, successor to the fixed 8x8 scanner in the minimal EDSAC display path.
- Generalised to ROWS x COLS.
- Internal scan timebase replaces the external scan clock.
- Adds valid/ready double-buffered frame loading, inter-row blanking against ghosting, and global PWM brightness.
- Drives logical row/column enables; the board-specific pin map and tristate primitives stay in the wrapper above it.

Parameters:
ROWS, 8, number of matrix rows (>=2)
COLS, 8, number of matrix columns (>=1)
DIV_W, 12, width of scan period input
PWM_BITS, 4, brightness resolution
BLANK_CYCLES, 2, all-off clocks before each row (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
div_i  in  DIV_W  row ON-phase length minus 1, in clk cycles
brightness  in  PWM_BITS  global duty; all-ones = 100%
frame_d  in  ROWS*COLS  pixel bits; pixel (r,c) = bit r*COLS+c, 1 = lit
frame_valid  in  1  frame_d offered
frame_ready  out  1  pending buffer free
row_on  out  ROWS  one-hot row select, 1 = row active
col_on  out  COLS  column drive, 1 = column sourcing
row_idx  out  $clog2(ROWS)  row currently scanned
frame_start  out  1  one-cycle pulse, first cycle of row 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- All outputs registered. Reset values:
  - row_on=0, col_on=0, row_idx=0, frame_start=0, frame_ready=0.
  - Active and pending buffers cleared; pending marked empty.
- Outside reset: frame_ready = !pend_full.
- FSM states:
  - S_BLANK: counter runs BLANK_CYCLES cycles; row_on=0, col_on=0. On the last cycle, latch div_i into the ON counter and go to S_ON.
  - S_ON: runs div_i+1 cycles. row_on=1<<row_idx. col_on=active[row_idx*COLS +: COLS] & {COLS{lit}}.
  - S_ON exit: after the last cycle, row_idx increments, wrapping ROWS-1 -> 0, and the FSM returns to S_BLANK.
- First cycle after reset release is S_BLANK, row 0, frame_start=1.
- Row period = BLANK_CYCLES + div_i + 1. Frame period = ROWS x row period.
- div_i is sampled only at S_BLANK->S_ON. A mid-row change takes effect on the next row.
- PWM:
  - pwm_cnt (PWM_BITS) clears on S_ON entry and increments every S_ON cycle, wrapping.
  - lit = (brightness==all-ones) | (pwm_cnt < brightness).
  - brightness=0 gives a dark display with the scan still running. brightness is sampled every cycle.
- Frame handshake:
  - Transfer when frame_valid & frame_ready: pending<=frame_d, pend_full<=1.
  - At wrap into row 0 (same edge that sets row_idx=0): if pend_full, active<=pending and pend_full<=0. This gives tear-free swaps at frame boundaries only.
  - Accept and swap never coincide, since ready=0 whenever a swap can happen.
  - A second offered frame is back-pressured until the swap.
- frame_start pulses on every S_BLANK entry for row 0.
- Reset mid-row: immediate return to reset state; the pending frame is discarded.

Optional Feature:
LED_SCAN_SKIP_EMPTY_EN
- Defined: a row whose active COLS bits are all zero skips S_ON. Its slot is BLANK_CYCLES only, then the FSM advances. This raises refresh rate for sparse images.
  - An all-zero frame still cycles through rows (BLANK only) and pulses frame_start, so swaps still occur.
  - div_i is not sampled for skipped rows.
- Undefined: every row gets the full S_ON phase regardless of content.

Decomposition:
- led_scan_pkg: state enum {S_BLANK, S_ON}; localparam function for row_idx width; pixel-index helper function.
- Sub-module led_frame_buf: pending/active registers, pend_full, frame_ready, swap input. The scanner FSM stays in led_matrix_scan.

Test Plan:
Common setup: ROWS=COLS=8, BLANK_CYCLES=2, PWM_BITS=4.
1. Reset then div_i=3, brightness=15, no frame -> row_on=0 for 2 cycles, then 01 for 4 cycles, then 02...; frame_start period 48 cycles; col_on always 0.
2. Load frame_d=64'h0000_0000_0000_00A5 mid-row 3 -> frame_ready drops next cycle; col_on stays 0 until row 0 of the next frame, then 8'hA5 during row 0 ON only; frame_ready returns 1 same cycle.
3. Offer two frames back-to-back (F1, F2) -> F2 held with frame_valid=1, ready=0, until the F1 swap; F2 displayed one frame after F1.
4. div_i=15, brightness=4, all-ones frame -> per row, col_on=FF for 4 cycles then 00 for 12; brightness=0 -> col_on never set while row_on still scans.
5. Change div_i 3->7 during S_ON of row 2 -> row 2 ON stays 4 cycles; row 3 ON is 8 cycles.
6. LED_SCAN_SKIP_EMPTY_EN, frame with only row 5 = 8'h01, div_i=3 -> frame period 8x2+4=20 cycles, row_on asserted only as 8'h20. Assert rst mid-row -> outputs 0 next cycle.
